// File: rtl/idelay_tap_cal.sv
// idelay_tap_cal: sweeps an IODELAY (VARIABLE mode) across all taps against an alternating
// training bit, records the longest error-free run of taps and parks the delay at its centre.
module idelay_tap_cal #(
  parameter int unsigned TAP_W   = 6,
  parameter int unsigned TAP_MAX = 63,
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned WINDOW  = 256
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             start,
  input  logic             idelay_ctrl_rdy,
  input  logic             train_bit,
  output logic             dly_rst,
  output logic             dly_ce,
  output logic             dly_inc,
  output logic [TAP_W-1:0] tap_value,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len,
  output logic             busy,
  output logic             cal_done,
  output logic             cal_fail
);

  localparam int unsigned CntMax = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  typedef enum logic [3:0] {
    StIdle, StWaitRdy, StDlyRst, StSettle, StSample, StEval, StStep, StMove, StDone, StFail
  } state_e;

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W:0]   best_len_q, best_len_d;
  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [TAP_W:0]   cur_len_q, cur_len_d;
  logic             err_q, err_d;
  logic             prev_q, prev_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             dly_rst_q, dly_rst_d;
  logic             dly_ce_q, dly_ce_d;
  logic             dly_inc_q, dly_inc_d;

  logic [TAP_W:0] cur_len_inc;
  logic [TAP_W:0] target;
  logic           at_max;
  logic           rdy_lost;

  assign cur_len_inc = cur_len_q + (TAP_W+1)'(1);
  // Centre of the best run, kept one bit wider so the sum cannot wrap.
  assign target      = {1'b0, best_start_q} + (best_len_q >> 1);
  assign at_max      = (tap_q == TAP_W'(TAP_MAX));
  assign rdy_lost    = !idelay_ctrl_rdy &&
                       (state_q inside {StDlyRst, StSettle, StSample, StEval, StStep, StMove});

  // Next-state and registered-output decisions; dly_* pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    err_d        = err_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    dly_rst_d    = 1'b0;
    dly_ce_d     = 1'b0;
    dly_inc_d    = 1'b0;

    if (rdy_lost) begin
      // Losing IDELAYCTRL invalidates every tap measured so far.
      state_d      = StWaitRdy;
      best_start_d = '0;
      best_len_d   = '0;
      cur_start_d  = '0;
      cur_len_d    = '0;
      err_d        = 1'b0;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StFail: begin
          if (start) begin
            state_d      = StWaitRdy;
            done_d       = 1'b0;
            fail_d       = 1'b0;
            best_start_d = '0;
            best_len_d   = '0;
            cur_start_d  = '0;
            cur_len_d    = '0;
            err_d        = 1'b0;
            busy_d       = 1'b1;
          end
        end
        StWaitRdy: begin
          if (idelay_ctrl_rdy) begin
            state_d   = StDlyRst;
            dly_rst_d = 1'b1;
            tap_d     = '0;
          end
        end
        StDlyRst: begin
          state_d = StSettle;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE - 1)) begin
            state_d = StSample;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSample: begin
          prev_d = train_bit;
          // The first sample has no predecessor; it only seeds prev.
          if (cnt_q != '0 && train_bit == prev_q) err_d = 1'b1;
          if (cnt_q == CntW'(WINDOW - 1)) begin
            state_d = StEval;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StEval: begin
          if (!err_q) begin
            cur_len_d = cur_len_inc;
            if (cur_len_q == '0) cur_start_d = tap_q;
            // Strict compare keeps the earlier run on a tie.
            if (cur_len_inc > best_len_q) begin
              best_start_d = (cur_len_q == '0) ? tap_q : cur_start_q;
              best_len_d   = cur_len_inc;
            end
          end else begin
            cur_len_d = '0;
          end
          if (at_max) begin
            state_d = StMove;
          end else begin
            state_d   = StStep;
            dly_ce_d  = 1'b1;
            dly_inc_d = 1'b1;
            tap_d     = tap_q + TAP_W'(1);
            err_d     = 1'b0;
          end
        end
        StStep: begin
          state_d = StSettle;
          cnt_d   = '0;
        end
        StMove: begin
          if (best_len_q == '0) begin
            state_d = StFail;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
          end else if ({1'b0, tap_q} > target) begin
            dly_ce_d = 1'b1;
            tap_d    = tap_q - TAP_W'(1);
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q      <= StIdle;
      tap_q        <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      err_q        <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      dly_rst_q    <= 1'b0;
      dly_ce_q     <= 1'b0;
      dly_inc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      err_q        <= err_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      dly_rst_q    <= dly_rst_d;
      dly_ce_q     <= dly_ce_d;
      dly_inc_q    <= dly_inc_d;
    end
  end

  assign dly_rst    = dly_rst_q;
  assign dly_ce     = dly_ce_q;
  assign dly_inc    = dly_inc_q;
  assign tap_value  = tap_q;
  assign best_start = best_start_q;
  assign best_len   = best_len_q;
  assign busy       = busy_q;
  assign cal_done   = done_q;
  assign cal_fail   = fail_q;

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Bench for idelay_tap_cal: an IODELAY model drives the training bit per tap, a reference
// model predicts the calibration result, and a monitor checks each completion.
module tb_idelay_tap_cal;

  localparam int unsigned TAP_W   = 6;
  localparam int unsigned TAP_MAX = 63;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned WINDOW  = 8;
  localparam int          BUDGET  = 3000;

  logic             clk_100MHz = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             idelay_ctrl_rdy = 1'b1;
  logic             train_bit = 1'b0;
  logic             dly_rst, dly_ce, dly_inc, busy, cal_done, cal_fail;
  logic [TAP_W-1:0] tap_value, best_start;
  logic [TAP_W:0]   best_len;

  always #5 clk_100MHz = ~clk_100MHz;

  idelay_tap_cal #(
    .TAP_W  (TAP_W),
    .TAP_MAX(TAP_MAX),
    .SETTLE (SETTLE),
    .WINDOW (WINDOW)
  ) dut (
    .clk_100MHz     (clk_100MHz),
    .rst            (rst),
    .start          (start),
    .idelay_ctrl_rdy(idelay_ctrl_rdy),
    .train_bit      (train_bit),
    .dly_rst        (dly_rst),
    .dly_ce         (dly_ce),
    .dly_inc        (dly_inc),
    .tap_value      (tap_value),
    .best_start     (best_start),
    .best_len       (best_len),
    .busy           (busy),
    .cal_done       (cal_done),
    .cal_fail       (cal_fail)
  );

  typedef struct {
    int bstart;
    int blen;
    int tap;
    int done;
    int decs;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   good [0:TAP_MAX];
  bit   stuck_val [0:TAP_MAX];
  int   tap_m = 0;
  int   dec_cnt = 0;
  int   rst_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  // IODELAY model: tracks the physical tap and presents the data bit seen at that tap.
  initial begin
    int t;
    forever begin
      @(negedge clk_100MHz);
      check("rst_ce_overlap", int'(dly_rst & dly_ce), 0);
      check("inc_without_ce", int'(dly_inc & ~dly_ce), 0);
      if (dly_rst) begin
        tap_m = 0;
        dec_cnt = 0;
        rst_pulses++;
      end else if (dly_ce) begin
        if (dly_inc) tap_m++;
        else begin
          tap_m--;
          dec_cnt++;
        end
      end
      t = (tap_m < 0) ? 0 : (tap_m > int'(TAP_MAX)) ? int'(TAP_MAX) : tap_m;
      if (good[t]) train_bit = ~train_bit;
      else train_bit = stuck_val[t];
    end
  end

  // Monitor: every rising cal_done/cal_fail consumes one scoreboard entry.
  initial begin
    logic pd, pf;
    exp_t e;
    pd = 1'b0;
    pf = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      if ((cal_done && !pd) || (cal_fail && !pf)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("best_start", int'(best_start), e.bstart);
          check("best_len", int'(best_len), e.blen);
          check("tap_value", int'(tap_value), e.tap);
          check("model_tap", tap_m, e.tap);
          check("cal_done", int'(cal_done), e.done);
          check("cal_fail", int'(cal_fail), 1 - e.done);
          check("busy_after_cal", int'(busy), 0);
          check("decrement_pulses", dec_cnt, e.decs);
        end
      end
      pd = cal_done;
      pf = cal_fail;
    end
  end

  // Reference: brute-force longest all-good tap range, earliest wins on equal length.
  task automatic push_expect();
    exp_t e;
    int   bs, bl, tgt;
    bit   ok;
    bs = 0;
    bl = 0;
    for (int s = 0; s <= int'(TAP_MAX); s++) begin
      for (int t = s; t <= int'(TAP_MAX); t++) begin
        ok = 1'b1;
        for (int k = s; k <= t; k++) if (!good[k]) ok = 1'b0;
        if (ok && (t - s + 1) > bl) begin
          bl = t - s + 1;
          bs = s;
        end
      end
    end
    e.bstart = bs;
    e.blen   = bl;
    if (bl == 0) begin
      e.done = 0;
      e.tap  = int'(TAP_MAX);
      e.decs = 0;
    end else begin
      tgt    = bs + bl / 2;
      e.done = 1;
      e.tap  = tgt;
      e.decs = int'(TAP_MAX) - tgt;
    end
    sb_q.push_back(e);
  endtask

  task automatic set_runs(input int lo0, input int hi0, input int lo1, input int hi1);
    for (int i = 0; i <= int'(TAP_MAX); i++) begin
      good[i]      = (i >= lo0 && i <= hi0) || (i >= lo1 && i <= hi1);
      stuck_val[i] = 1'($urandom);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!(cal_done || cal_fail) && k < BUDGET) begin
      tick(1);
      k++;
    end
    if (k >= BUDGET) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no completion after %0d cycles, expected done or fail", name, k);
    end
    tick(2);
  endtask

  task automatic wait_tap(input string name, input int t);
    int k = 0;
    while (tap_m != t && k < BUDGET) begin
      tick(1);
      k++;
    end
    if (k >= BUDGET) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_tap_timeout: model tap %0d, expected to reach %0d", name, tap_m, t);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_dly_rst"}, int'(dly_rst), 0);
    check({name, "_dly_ce"}, int'(dly_ce), 0);
    check({name, "_dly_inc"}, int'(dly_inc), 0);
    check({name, "_tap_value"}, int'(tap_value), 0);
    check({name, "_best_start"}, int'(best_start), 0);
    check({name, "_best_len"}, int'(best_len), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_cal_done"}, int'(cal_done), 0);
    check({name, "_cal_fail"}, int'(cal_fail), 0);
  endtask

  initial begin
    int rp, k;
    set_runs(0, 63, -1, -1);
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(1);

    // Ready low at start; dly_rst must follow the rise by one cycle.
    idelay_ctrl_rdy = 1'b0;
    push_expect();
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    rp = rst_pulses;
    tick(99);
    check("no_dly_rst_before_rdy", rst_pulses - rp, 0);
    idelay_ctrl_rdy = 1'b1;
    tick(1);
    check("dly_rst_after_rdy", int'(dly_rst), 1);
    wait_done("all_good");

    set_runs(10, 20, -1, -1);
    push_expect();
    pulse_start();
    wait_done("run_10_20");

    set_runs(5, 8, 40, 43);
    push_expect();
    pulse_start();
    wait_done("tie_runs");

    set_runs(-1, -1, -1, -1);
    push_expect();
    pulse_start();
    wait_done("all_bad");

    // Ready drop mid-sweep restarts from a fresh dly_rst.
    set_runs(0, 63, -1, -1);
    push_expect();
    pulse_start();
    wait_tap("rdy_drop", 30);
    tick(3);
    check("best_len_before_drop", int'(best_len != 0), 1);
    idelay_ctrl_rdy = 1'b0;
    tick(2);
    check("best_len_cleared_on_drop", int'(best_len), 0);
    check("busy_during_drop", int'(busy), 1);
    rp = rst_pulses;
    tick(10);
    check("no_dly_rst_while_dropped", rst_pulses - rp, 0);
    idelay_ctrl_rdy = 1'b1;
    tick(1);
    check("fresh_dly_rst", int'(dly_rst), 1);
    wait_done("rdy_drop");

    // Reset mid-SAMPLE.
    set_runs(10, 20, -1, -1);
    push_expect();
    pulse_start();
    wait_tap("rst_sample", 5);
    tick(5);
    rst = 1'b1;
    sb_q.delete();
    tick(1);
    check_zero("rst_sample");
    rst = 1'b0;
    tick(2);

    // Reset mid-MOVE.
    set_runs(0, 63, -1, -1);
    push_expect();
    pulse_start();
    k = 0;
    while (!(dly_ce && !dly_inc) && k < BUDGET) begin
      tick(1);
      k++;
    end
    check("move_reached", int'(k < BUDGET), 1);
    tick(3);
    rst = 1'b1;
    sb_q.delete();
    tick(1);
    check_zero("rst_move");
    rst = 1'b0;
    tick(2);

    // A start pulse while busy must not disturb the sweep.
    set_runs(10, 20, -1, -1);
    push_expect();
    pulse_start();
    wait_tap("start_busy", 25);
    tick(3);
    pulse_start();
    check("best_len_kept", int'(best_len), 11);
    check("best_start_kept", int'(best_start), 10);
    check("busy_kept", int'(busy), 1);
    wait_done("start_busy");

    // Random good/bad tap maps.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i <= int'(TAP_MAX); i++) begin
        good[i]      = ($urandom_range(0, 3) != 0);
        stuck_val[i] = 1'($urandom);
      end
      push_expect();
      pulse_start();
      wait_done("random");
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idelay_tap_cal.md
# idelay_tap_cal

Calibrates a Virtex-5 IDELAY tap in VARIABLE mode for one VGA input bit. It waits for the IDELAYCTRL ready flag produced by the 200 MHz IDELAYCTRL wrapper, then sweeps taps 0..TAP_MAX against a toggling training pattern. It finds the longest run of error-free taps and parks the delay at the centre of that run. The block sits in the 100 MHz fabric domain between the IDELAYCTRL wrapper and the IODELAY primitive of the capture path.

## Interface
- TAP_W, 6: tap counter width.
- TAP_MAX, 63: highest tap index swept.
- SETTLE, 8: idle cycles after each tap change before sampling starts (≥1).
- WINDOW, 256: samples checked per tap (≥2).
- clk_100MHz  in  1  fabric clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle calibration request.
- idelay_ctrl_rdy  in  1  IDELAYCTRL ready, already synchronous to clk_100MHz.
- train_bit  in  1  delayed, registered data bit carrying the alternating 0/1 training pattern.
- dly_rst  out  1  IODELAY RST pulse; resets the tap to 0.
- dly_ce  out  1  IODELAY CE; one tap step per asserted cycle.
- dly_inc  out  1  IODELAY INC; 1 = increment, 0 = decrement. Meaningful only with dly_ce.
- tap_value  out  TAP_W  current tap as tracked by the block.
- best_start  out  TAP_W  first tap of the best window.
- best_len  out  TAP_W+1  length of the best window (0 = none found).
- busy  out  1  calibration in progress.
- cal_done  out  1  level; calibration succeeded and the delay is parked.
- cal_fail  out  1  level; no good tap was found.

## Operation
- Reset values: all outputs 0; state IDLE.
- States: IDLE, WAIT_RDY, DLY_RST, SETTLE, SAMPLE, EVAL, STEP, MOVE, DONE, FAIL.
- IDLE, DONE or FAIL with start=1 → WAIT_RDY.
  - Clear cal_done, cal_fail, best_start, best_len and the current run.
  - Set busy=1.
  - start is ignored while busy.
- WAIT_RDY: stay until idelay_ctrl_rdy=1, then → DLY_RST.
- DLY_RST: dly_rst=1 for exactly 1 cycle, tap_value←0, then → SETTLE.
- SETTLE: counts SETTLE cycles, then → SAMPLE.
- SAMPLE: lasts WINDOW cycles.
  - The first cycle only loads prev←train_bit.
  - Each later cycle sets a sticky err if train_bit == prev, then updates prev.
- EVAL: 1 cycle.
  - Good tap (err=0):
    - cur_len++.
    - If cur_len was 0, cur_start←tap_value.
    - If the new cur_len > best_len (strictly), best_start←cur_start and best_len←new cur_len. On a tie the earlier run is kept.
  - Bad tap: cur_len←0.
  - Then: if tap_value==TAP_MAX → MOVE; else → STEP.
- STEP: dly_ce=1 and dly_inc=1 for 1 cycle, tap_value++, clear err, then → SETTLE.
- MOVE:
  - If best_len==0 → FAIL.
  - Otherwise target = best_start + (best_len>>1), computed in TAP_W+1 bits.
  - While tap_value > target, assert dly_ce=1 and dly_inc=0 and decrement tap_value, one tap per cycle, back-to-back.
  - When tap_value==target → DONE.
- DONE: cal_done=1, busy=0. Hold until rst or start.
- FAIL: cal_fail=1, busy=0. Hold until rst or start.
- idelay_ctrl_rdy falling to 0 in any busy state other than WAIT_RDY → WAIT_RDY; the run and best values are cleared.
- rst at any cycle, including mid-MOVE, forces IDLE and zeroes every output on the next edge. No dly_* pulse is issued on that edge.
- dly_rst and dly_ce are never asserted in the same cycle. dly_inc=0 whenever dly_ce=0.

## Timing
- All outputs are registered.
- start → busy high: next edge.
- WAIT_RDY exit: 1 cycle after idelay_ctrl_rdy is sampled high.
- Cycles per tap: SETTLE + WINDOW + 1 (EVAL), plus 1 STEP cycle for every tap except TAP_MAX.
- Sweep with defaults: 64·265 + 63 = 17023 cycles after DLY_RST.
- MOVE: (TAP_MAX − target) dly_ce cycles, plus 1 cycle to enter DONE.
- tap_value changes on the same edge that asserts dly_ce or dly_rst.

## Test plan
- Bench IODELAY model tracks the tap from dly_rst/dly_ce/dly_inc. train_bit toggles at every tap → best_start=0, best_len=64, 31 decrement pulses, final tap_value=32, cal_done=1.
- train_bit toggles only at taps 10..20 (stuck otherwise) → best_start=10, best_len=11, final tap_value=15, cal_done=1, cal_fail=0.
- Good taps 5..8 and 40..43 (equal length-4 runs) → best_start=5, final tap_value=7.
- train_bit constant at all taps → cal_fail=1, cal_done=0, best_len=0, no decrement pulses.
- idelay_ctrl_rdy low at start, rising 100 cycles later → first dly_rst exactly 1 cycle after the rise. Dropping rdy at tap 30 → return to WAIT_RDY, with a fresh dly_rst after rdy returns.
- rst asserted mid-SAMPLE and again mid-MOVE → the next cycle shows all outputs 0 and state IDLE. A subsequent start calibrates correctly; a start pulse while busy has no effect.
